lanzones_lsu: RTL and testbench
===============================

Name: lanzones_lsu

Overview:
Load/store unit between the lanzones core's memory-stage request and the shared RRdy/RVld memory port.
- Accepts one byte-addressed load or store with a RISC-V funct3 size code.
- Converts it to a word-aligned bus access with byte strobes and lane-replicated write data.
- For loads, waits for RVld, then extracts, shifts and sign/zero-extends the returned word.
- Reports misaligned, illegal and timed-out accesses as errors without corrupting memory.

Parameters:
WORD_ADDR, 0, 0: RAddr = {ReqAddr[31:2],2'b00}; 1: RAddr = {2'b00,ReqAddr[31:2]} (word-indexed memory)
TIMEOUT, 64, max cycles spent in READ waiting for RVld before an error response; 0 disables the timeout
CNT_W, 7, width of the timeout counter; must satisfy CNT_W >= clog2(TIMEOUT+1)

Ports:
clk  input  1  core clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
ReqVld  input  1  upstream request valid
ReqRdy  output  1  LSU can accept a request; high only in IDLE
ReqWe  input  1  1 = store, 0 = load
ReqFunct3  input  3  load: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; store: 0 SB, 1 SH, 2 SW
ReqAddr  input  32  byte address
ReqWData  input  32  store data, right-justified
RespVld  output  1  one-cycle response pulse
RespData  output  32  extended load data; 0 for stores and errors
RespErr  output  1  valid with RespVld: misaligned, illegal funct3 or timeout
RRdy  output  1  memory read request, held until RVld
RVld  input  1  memory read data valid
RAddr  output  32  memory address
RData  input  32  memory read data, sampled only when RVld=1
RWEn  output  1  memory write enable, exactly one cycle per store
RWStrobe  output  4  byte lane enables
RWData  output  32  lane-replicated write data

Behaviour:
- Reset (rstn=0, asynchronous): state IDLE, counter 0, captured request registers 0. All outputs 0 except ReqRdy=1.
- Reset mid-operation aborts the access with no response. A pending memory RVld after reset is ignored.
- States: IDLE, READ, WRITE, RESP. ReqRdy = (state==IDLE).
- Acceptance: ReqVld && ReqRdy at an edge captures ReqWe, ReqFunct3, ReqAddr and ReqWData. ReqVld is ignored outside IDLE.
- Legality check at acceptance:
  - Halfword requires Addr[0]=0; word requires Addr[1:0]=0.
  - Illegal codes: loads 3/6/7, stores 3-7.
  - Any failure -> RESP with RespErr=1. No RRdy or RWEn is issued.
- IDLE -> WRITE for a legal store.
  - WRITE lasts exactly one cycle: RWEn=1, RAddr per WORD_ADDR.
  - SB: RWStrobe = 4'b0001<<Addr[1:0], RWData = {4{WData[7:0]}}.
  - SH: RWStrobe = Addr[1] ? 4'b1100 : 4'b0011, RWData = {2{WData[15:0]}}.
  - SW: RWStrobe = 4'b1111, RWData = WData.
  - WRITE -> RESP.
- IDLE -> READ for a legal load.
  - RRdy=1, RAddr valid, RWStrobe=0, RWData=0, RWEn=0.
  - On the edge where RVld=1 is sampled: capture RData, shifted right by 8*Addr[1:0] and extended per funct3; go to RESP. RRdy drops in the same cycle.
  - Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- Timeout: the counter increments each READ cycle without RVld. When it reaches TIMEOUT (TIMEOUT != 0): RESP with RespErr=1, RespData=0. The counter clears on leaving READ.
- RESP: RespVld=1 for exactly one cycle, then IDLE. RespData/RespErr are registered and are 0 whenever RespVld=0.
- Latency from the accepting edge, with a memory that raises RVld the cycle after RRdy:
  - load: RespVld in the 3rd cycle;
  - store: RespVld in the 2nd cycle;
  - error: RespVld in the 1st cycle.
- Back-to-back requests: the next request is accepted on the edge that ends RESP only if ReqRdy was already high. The earliest is the cycle after RESP, because ReqRdy=0 during RESP.
- When not in READ, RRdy=0. When not in WRITE, RWEn=0 and RWStrobe=0.
- RAddr = 0 in IDLE and RESP.

Test Plan:
1. Preload word 0x100 = 0x8899AABB; LB at addr 0x103 -> RRdy held 2 cycles, RespVld with RespData=0xFFFFFF88, RespErr=0. Then LBU at 0x103 -> 0x00000088.
2. Word 0x200 = 0x11223344; SH 0xBEEF at 0x202 -> single RWEn cycle with RWStrobe=1100 and RWData=0xBEEFBEEF. LW 0x200 then returns 0xBEEF3344.
3. LW at 0x101 and SH at 0x203 -> each gives RespVld+RespErr one cycle after accept; RRdy and RWEn stay 0 throughout; memory unchanged.
4. ReqFunct3=3 load and ReqFunct3=4 store -> RespErr=1, no bus activity.
5. TIMEOUT=4, memory holds RVld=0 -> RRdy high exactly 4 cycles, then RespVld, RespErr=1, RespData=0, state back to IDLE.
6. Assert rstn=0 while in READ, with RVld arriving during reset -> no RespVld; outputs at reset values. After release, LW 0x100 returns 0x8899AABB.

Source files
------------

// File: rtl/lanzones_lsu.sv
// lanzones_lsu: load/store unit bridging core memory-stage requests to the RRdy/RVld memory port
// Ports: clk/rstn clock and async active-low reset; ReqVld/ReqRdy/ReqWe/ReqFunct3/ReqAddr/ReqWData
//        upstream request; RespVld/RespData/RespErr one-cycle response; RRdy/RVld/RData read
//        handshake; RAddr memory address; RWEn/RWStrobe/RWData single-cycle write.
module lanzones_lsu #(
  parameter int WORD_ADDR = 0,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 7
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ReqVld,
  output logic        ReqRdy,
  input  logic        ReqWe,
  input  logic [2:0]  ReqFunct3,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespVld,
  output logic [31:0] RespData,
  output logic        RespErr,
  output logic        RRdy,
  input  logic        RVld,
  output logic [31:0] RAddr,
  input  logic [31:0] RData,
  output logic        RWEn,
  output logic [3:0]  RWStrobe,
  output logic [31:0] RWData
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic we_q, we_d, err_q, err_d, bad, timeout;
  logic [2:0] f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, resp_q, resp_d, shifted, ext;
  // size code 3 is never legal; bit 2 is legal only for LBU/LHU
  assign bad = (ReqFunct3[1:0] == 2'b11) || (ReqFunct3[2] && (ReqWe || ReqFunct3[1]))
             || (ReqFunct3[1:0] == 2'b01 && ReqAddr[0])
             || (ReqFunct3[1:0] == 2'b10 && |ReqAddr[1:0]);
  assign shifted = RData >> {addr_q[1:0], 3'b000};
  // f3_q[2] marks the unsigned loads, so it suppresses sign replication
  assign ext = f3_q[1:0] == 2'b00 ? {{24{shifted[7] & ~f3_q[2]}}, shifted[7:0]}
             : f3_q[1:0] == 2'b01 ? {{16{shifted[15] & ~f3_q[2]}}, shifted[15:0]} : shifted;
  assign timeout = TIMEOUT != 0 && (cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT);
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (ReqVld) begin
        we_d    = ReqWe;
        f3_d    = ReqFunct3;
        addr_d  = ReqAddr;
        wdata_d = ReqWData;
        err_d   = bad;
        state_d = bad ? RESP : ReqWe ? WRITE : READ;
      end
      READ: if (RVld) begin
        state_d = RESP;
        resp_d  = ext;
      end else if (timeout) begin
        state_d = RESP;
        err_d   = 1'b1;
      end else cnt_d = cnt_q + CNT_W'(1);
      WRITE: state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end
  assign ReqRdy   = state_q == IDLE;
  assign RRdy     = state_q == READ;
  assign RWEn     = state_q == WRITE;
  assign RespVld  = state_q == RESP;
  assign RespData = resp_q;
  assign RespErr  = err_q;
  assign RAddr    = !(RRdy || RWEn) ? '0
                  : WORD_ADDR != 0 ? {2'b00, addr_q[31:2]} : {addr_q[31:2], 2'b00};
  assign RWStrobe = !RWEn ? 4'b0000
                  : f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0]
                  : f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign RWData   = !RWEn ? '0
                  : f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}}
                  : f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
  logic unused;
  assign unused = we_q;
endmodule

// File: tb/tb_lanzones_lsu.sv
// tb_lanzones_lsu: directed scoreboard bench for lanzones_lsu with a simple word memory model
module tb_lanzones_lsu;
  logic clk = 1'b0, rstn = 1'b0;
  logic ReqVld = 1'b0, ReqWe = 1'b0;
  logic [2:0] ReqFunct3 = '0;
  logic [31:0] ReqAddr = '0, ReqWData = '0;
  logic ReqRdy, RespVld, RespErr, RRdy, RVld, RWEn;
  logic [31:0] RespData, RAddr, RData, RWData;
  logic [3:0] RWStrobe;
  logic mem_rvld = 1'b0, stall = 1'b0, force_rvld = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [0:255];
  int n_vec = 0, n_bad = 0;
  typedef struct {logic [31:0] d; logic e;} exp_t;
  exp_t sb[$];

  lanzones_lsu #(.WORD_ADDR(0), .TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rstn(rstn), .ReqVld(ReqVld), .ReqRdy(ReqRdy), .ReqWe(ReqWe),
    .ReqFunct3(ReqFunct3), .ReqAddr(ReqAddr), .ReqWData(ReqWData), .RespVld(RespVld),
    .RespData(RespData), .RespErr(RespErr), .RRdy(RRdy), .RVld(RVld), .RAddr(RAddr),
    .RData(RData), .RWEn(RWEn), .RWStrobe(RWStrobe), .RWData(RWData));

  always #5 clk = ~clk;
  assign RVld  = (mem_rvld && !stall) || force_rvld;
  assign RData = mem_rdata;

  always @(posedge clk) begin
    logic [31:0] w;
    mem_rvld  <= RRdy && !mem_rvld && !stall;
    mem_rdata <= mem[RAddr[9:2]];
    if (RWEn) begin
      w = mem[RAddr[9:2]];
      for (int i = 0; i < 4; i++) if (RWStrobe[i]) w[8*i +: 8] = RWData[8*i +: 8];
      mem[RAddr[9:2]] = w;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn && RespVld) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL resp_unexpected: got data %h err %b want no response", RespData, RespErr);
      end else begin
        e = sb.pop_front();
        if (RespData !== e.d || RespErr !== e.e) begin
          n_bad++;
          $display("FAIL resp: got data %h err %b want data %h err %b", RespData, RespErr, e.d, e.e);
        end
      end
    end else if (rstn) begin
      n_vec++;
      if (RespData !== '0 || RespErr !== 1'b0) begin
        n_bad++;
        $display("FAIL resp_idle: got data %h err %b want 0 0", RespData, RespErr);
      end
    end
  end

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] ed, input logic ee, input int elat, input int err_cyc,
                     input int ewe, input logic [3:0] es, input logic [31:0] ewd);
    int lat = 0, rr = 0, wc = 0;
    bit done = 0;
    @(negedge clk);
    chk("req_rdy", ReqRdy, 1);
    ReqVld = 1'b1; ReqWe = we; ReqFunct3 = f3; ReqAddr = a; ReqWData = wd;
    sb.push_back('{ed, ee});
    @(posedge clk);
    #1 ReqVld = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      lat++;
      rr += int'(RRdy);
      if (RWEn) begin
        wc++;
        chk("wr_strobe", {28'd0, RWStrobe}, {28'd0, es});
        chk("wr_data", RWData, ewd);
        chk("wr_addr", RAddr, {a[31:2], 2'b00});
      end
      if (RespVld) done = 1;
    end
    chk("latency", lat, elat);
    chk("rrdy_cycles", rr, err_cyc);
    chk("rwen_cycles", wc, ewe);
  endtask

  task automatic chk_reset_outs();
    chk("rst_reqrdy", ReqRdy, 1);
    chk("rst_rrdy", RRdy, 0);
    chk("rst_respvld", RespVld, 0);
    chk("rst_resp", {RespErr, RespData[30:0]} | RespData, 0);
    chk("rst_raddr", RAddr, 0);
    chk("rst_wr", {RWEn, RWStrobe} | 5'(RWData != 0), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem['h100 >> 2] = 32'h8899AABB;
    mem['h200 >> 2] = 32'h11223344;
    #1 chk_reset_outs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    // sign/zero-extended byte loads from the top lane
    req(0, 3'd0, 32'h103, 0, 32'hFFFFFF88, 0, 3, 2, 0, 0, 0);
    req(0, 3'd4, 32'h103, 0, 32'h00000088, 0, 3, 2, 0, 0, 0);
    // halfword store to the upper half, then read back
    req(1, 3'd1, 32'h202, 32'h0000BEEF, 0, 0, 2, 0, 1, 4'b1100, 32'hBEEFBEEF);
    req(0, 3'd2, 32'h200, 0, 32'hBEEF3344, 0, 3, 2, 0, 0, 0);
    // misaligned and illegal codes respond immediately with no bus traffic
    req(0, 3'd2, 32'h101, 0, 0, 1, 1, 0, 0, 0, 0);
    req(1, 3'd1, 32'h203, 32'h1234, 0, 1, 1, 0, 0, 0, 0);
    req(0, 3'd3, 32'h100, 0, 0, 1, 1, 0, 0, 0, 0);
    req(1, 3'd4, 32'h200, 32'h5555, 0, 1, 1, 0, 0, 0, 0);
    chk("mem_200_intact", mem['h200 >> 2], 32'hBEEF3344);
    chk("mem_100_intact", mem['h100 >> 2], 32'h8899AABB);
    // byte store in lane 1, halfword loads both signednesses
    req(1, 3'd0, 32'h301, 32'hFFFF_FFA5, 0, 0, 2, 0, 1, 4'b0010, 32'hA5A5A5A5);
    req(0, 3'd1, 32'h300, 0, 32'hFFFFA500, 0, 3, 2, 0, 0, 0);
    req(0, 3'd5, 32'h300, 0, 32'h0000A500, 0, 3, 2, 0, 0, 0);
    req(0, 3'd1, 32'h102, 0, 32'hFFFF8899, 0, 3, 2, 0, 0, 0);
    req(1, 3'd2, 32'h304, 32'hCAFEF00D, 0, 0, 2, 0, 1, 4'b1111, 32'hCAFEF00D);
    req(0, 3'd2, 32'h304, 0, 32'hCAFEF00D, 0, 3, 2, 0, 0, 0);
    chk("mem_300", mem['h300 >> 2], 32'h0000A500);
    // timeout: RVld never comes
    stall = 1'b1;
    req(0, 3'd2, 32'h100, 0, 0, 1, 5, 4, 0, 0, 0);
    @(negedge clk);
    chk("timeout_idle", ReqRdy, 1);
    // reset while waiting in READ, RVld asserted during reset
    ReqVld = 1'b1; ReqWe = 1'b0; ReqFunct3 = 3'd2; ReqAddr = 32'h100;
    @(posedge clk);
    #1 ReqVld = 1'b0;
    @(negedge clk);
    chk("t6_in_read", RRdy, 1);
    #1 rstn = 1'b0; force_rvld = 1'b1;
    #1 chk_reset_outs();
    repeat (2) @(negedge clk);
    force_rvld = 1'b0;
    chk_reset_outs();
    rstn = 1'b1; stall = 1'b0;
    repeat (3) @(negedge clk);
    req(0, 3'd2, 32'h100, 0, 32'h8899AABB, 0, 3, 2, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
